// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter.
// FSM encoding, bit-time derivation and frame-length constants.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;

  function automatic int calc_bit_time(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// baud_gen: per-bit cycle counter for the UART transmitter.
// Pulses bit_done in the last cycle (count BIT_TIME-1) of each bit.
module baud_gen #(
  parameter int BIT_TIME = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  if (BIT_TIME < 2) begin : g_bad_bit_time
    $error("baud_gen: BIT_TIME must be at least 2");
  end

  localparam int CW = (BIT_TIME < 2) ? 1 : $clog2(BIT_TIME);
  localparam logic [CW-1:0] LAST = CW'(BIT_TIME - 1);

  logic [CW-1:0] cnt;

  assign bit_done = enable && (cnt == LAST);

  // Count cycles within a bit; wrap at the last cycle, zero on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with optional parity.
// One-byte holding register double-buffers writes against the shifter.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       SYS_CLK,
  input  logic       SYS_RST,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_TX,
  output logic       o_TXRDY,
  output logic       o_BUSY
);

  localparam int BIT_TIME = calc_bit_time(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  localparam logic PAR_EN = (PARITY_EN != 0);

  state_t     state, state_n;
  logic       tx, tx_n;
  logic       busy, busy_n;
  logic [7:0] shift, shift_n;
  logic [2:0] idx, idx_n;
  logic       par, par_n;
  logic [7:0] hold, hold_n;
  logic       hold_full, hold_full_n;
  logic       xfer;
  logic       bit_clear;
  logic       bit_en;
  logic       bit_done;

  assign o_TX    = tx;
  assign o_BUSY  = busy;
  assign o_TXRDY = !hold_full;

  assign bit_en    = (state != S_IDLE);
  assign bit_clear = (state_n != state) || (state == S_IDLE);

  baud_gen #(
    .BIT_TIME(BIT_TIME)
  ) u_baud (
    .clk     (SYS_CLK),
    .rst_n   (SYS_RST),
    .clear   (bit_clear),
    .enable  (bit_en),
    .bit_done(bit_done)
  );

  // State, line and buffer registers; reset aborts any frame at once.
  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      state     <= S_IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      shift     <= '0;
      idx       <= '0;
      par       <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      tx        <= tx_n;
      busy      <= busy_n;
      shift     <= shift_n;
      idx       <= idx_n;
      par       <= par_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
    end
  end

  // Next-state, next line bit, holding-register accept and transfer.
  always_comb begin
    state_n     = state;
    tx_n        = tx;
    shift_n     = shift;
    idx_n       = idx;
    par_n       = par;
    hold_n      = hold;
    hold_full_n = hold_full;
    xfer        = 1'b0;

    if (i_load && !hold_full) begin
      hold_n      = i_data;
      hold_full_n = 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        if (hold_full) begin
          xfer = 1'b1;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_n = S_DATA;
          idx_n   = '0;
          tx_n    = shift[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (idx == LAST_IDX) begin
            if (PAR_EN) begin
              state_n = S_PARITY;
              tx_n    = par;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n   = idx + 3'd1;
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (hold_full) begin
            xfer = 1'b1;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase

    if (xfer) begin
      state_n     = S_START;
      tx_n        = 1'b0;
      shift_n     = hold;
      par_n       = (^hold) ^ PAR_ODD;
      hold_full_n = 1'b0;
    end

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
// BIT_TIME=10 (1 MHz clock, 100 kbaud); cycle 0 = load sample cycle.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       ld, ld_pe, ld_po;
  logic       tx, rdy, busy;
  logic       tx_pe, rdy_pe, busy_pe;
  logic       tx_po, rdy_po, busy_po;

  int total;
  int bad;
  int cur;

  uart_tx #(
    .CLK_FREQ(1_000_000), .BAUD(100_000),
    .PARITY_EN(0), .PARITY_ODD(0)
  ) dut (
    .SYS_CLK(clk), .SYS_RST(rst_n),
    .i_load(ld), .i_data(din),
    .o_TX(tx), .o_TXRDY(rdy), .o_BUSY(busy)
  );

  uart_tx #(
    .CLK_FREQ(1_000_000), .BAUD(100_000),
    .PARITY_EN(1), .PARITY_ODD(0)
  ) dut_pe (
    .SYS_CLK(clk), .SYS_RST(rst_n),
    .i_load(ld_pe), .i_data(din),
    .o_TX(tx_pe), .o_TXRDY(rdy_pe), .o_BUSY(busy_pe)
  );

  uart_tx #(
    .CLK_FREQ(1_000_000), .BAUD(100_000),
    .PARITY_EN(1), .PARITY_ODD(1)
  ) dut_po (
    .SYS_CLK(clk), .SYS_RST(rst_n),
    .i_load(ld_po), .i_data(din),
    .o_TX(tx_po), .o_TXRDY(rdy_po), .o_BUSY(busy_po)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic go(input int n);
    repeat (n - cur) @(posedge clk);
    #1;
    cur = n;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ld = 0; ld_pe = 0; ld_po = 0;
    din = '0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (tx !== 1'b1 || rdy !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold tx/rdy/busy=%b%b%b want 110",
               tx, rdy, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cur = 0;
    for (int n = 1; n <= 200; n++) begin
      go(n);
      total++;
      if (tx !== 1'b1 || rdy !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle c%0d tx/rdy/busy=%b%b%b want 110",
                 n, tx, rdy, busy);
      end
    end
  endtask

  task automatic test_single;
    logic [9:0] f;
    f = {1'b1, 8'h55, 1'b0};
    cur = 0;
    din = 8'h55;
    ld = 1;
    go(1);
    ld = 0;
    total++;
    if (tx !== 1'b1 || rdy !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_c1 tx/rdy/busy=%b%b%b want 100",
               tx, rdy, busy);
    end
    for (int n = 2; n <= 101; n++) begin
      go(n);
      total++;
      if (tx !== f[(n - 2) / 10]) begin
        bad++;
        $display("FAIL single_bit c%0d tx=%b want %b",
                 n, tx, f[(n - 2) / 10]);
      end
      if (n == 2) begin
        total++;
        if (rdy !== 1'b1 || busy !== 1'b1) begin
          bad++;
          $display("FAIL single_c2 rdy/busy=%b%b want 11", rdy, busy);
        end
      end
      if (n == 101) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL single_c101 busy=%b want 1", busy);
        end
      end
    end
    go(102);
    total++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL single_c102 busy/tx=%b%b want 01", busy, tx);
    end
    go(112);
  endtask

  task automatic test_back_to_back;
    logic [9:0] f1, f2;
    logic       e;
    f1 = {1'b1, 8'hA3, 1'b0};
    f2 = {1'b1, 8'h0F, 1'b0};
    cur = 0;
    din = 8'hA3;
    ld = 1;
    go(1);
    ld = 0;
    go(5);
    total++;
    if (rdy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_rdy_c5 rdy=%b want 1", rdy);
    end
    din = 8'h0F;
    ld = 1;
    go(6);
    ld = 0;
    for (int n = 6; n <= 201; n++) begin
      go(n);
      e = (n < 102) ? f1[(n - 2) / 10] : f2[(n - 102) / 10];
      total++;
      if (tx !== e) begin
        bad++;
        $display("FAIL b2b_bit c%0d tx=%b want %b", n, tx, e);
      end
      if (n == 101) begin
        total++;
        if (rdy !== 1'b0) begin
          bad++;
          $display("FAIL b2b_rdy_c101 rdy=%b want 0", rdy);
        end
      end
      if (n == 102) begin
        total++;
        if (rdy !== 1'b1 || busy !== 1'b1) begin
          bad++;
          $display("FAIL b2b_c102 rdy/busy=%b%b want 11", rdy, busy);
        end
      end
    end
    go(202);
    total++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL b2b_end busy/tx=%b%b want 01", busy, tx);
    end
    go(212);
  endtask

  task automatic test_overwrite;
    logic [9:0] f1, f2;
    logic       e;
    f1 = {1'b1, 8'h11, 1'b0};
    f2 = {1'b1, 8'h22, 1'b0};
    cur = 0;
    din = 8'h11;
    ld = 1;
    go(1);
    ld = 0;
    go(2);
    total++;
    if (rdy !== 1'b1 || tx !== 1'b0) begin
      bad++;
      $display("FAIL ovw_c2 rdy/tx=%b%b want 10", rdy, tx);
    end
    din = 8'h22;
    ld = 1;
    go(3);
    total++;
    if (rdy !== 1'b0) begin
      bad++;
      $display("FAIL ovw_c3 rdy=%b want 0", rdy);
    end
    din = 8'h33;
    go(4);
    ld = 0;
    for (int n = 4; n <= 201; n++) begin
      go(n);
      e = (n < 102) ? f1[(n - 2) / 10] : f2[(n - 102) / 10];
      total++;
      if (tx !== e) begin
        bad++;
        $display("FAIL ovw_bit c%0d tx=%b want %b", n, tx, e);
      end
    end
    for (int n = 202; n <= 240; n++) begin
      go(n);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || rdy !== 1'b1) begin
        bad++;
        $display("FAIL ovw_idle c%0d tx/busy/rdy=%b%b%b want 101",
                 n, tx, busy, rdy);
      end
    end
  endtask

  task automatic test_parity;
    logic [10:0] fe, fo;
    fe = {1'b1, 1'b1, 8'h07, 1'b0};
    fo = {1'b1, 1'b0, 8'h07, 1'b0};
    cur = 0;
    din = 8'h07;
    ld_pe = 1;
    ld_po = 1;
    go(1);
    ld_pe = 0;
    ld_po = 0;
    for (int n = 2; n <= 111; n++) begin
      go(n);
      total++;
      if (tx_pe !== fe[(n - 2) / 10]) begin
        bad++;
        $display("FAIL par_even c%0d tx=%b want %b",
                 n, tx_pe, fe[(n - 2) / 10]);
      end
      total++;
      if (tx_po !== fo[(n - 2) / 10]) begin
        bad++;
        $display("FAIL par_odd c%0d tx=%b want %b",
                 n, tx_po, fo[(n - 2) / 10]);
      end
      if (n == 111) begin
        total++;
        if (busy_pe !== 1'b1 || busy_po !== 1'b1) begin
          bad++;
          $display("FAIL par_c111 busy e/o=%b%b want 11",
                   busy_pe, busy_po);
        end
      end
    end
    go(112);
    total++;
    if (busy_pe !== 1'b0 || busy_po !== 1'b0) begin
      bad++;
      $display("FAIL par_c112 busy e/o=%b%b want 00", busy_pe, busy_po);
    end
    go(120);
  endtask

  task automatic test_mid_reset;
    logic [9:0] f;
    f = {1'b1, 8'h81, 1'b0};
    cur = 0;
    din = 8'hFF;
    ld = 1;
    go(1);
    ld = 0;
    go(5);
    din = 8'h3C;
    ld = 1;
    go(6);
    ld = 0;
    go(45);
    total++;
    if (busy !== 1'b1 || rdy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL mrst_pre busy/rdy/tx=%b%b%b want 101",
               busy, rdy, tx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || rdy !== 1'b1) begin
      bad++;
      $display("FAIL mrst_async tx/busy/rdy=%b%b%b want 101",
               tx, busy, rdy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cur = 0;
    for (int n = 1; n <= 30; n++) begin
      go(n);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL mrst_idle c%0d tx/busy=%b%b want 10",
                 n, tx, busy);
      end
    end
    cur = 0;
    din = 8'h81;
    ld = 1;
    go(1);
    ld = 0;
    for (int n = 2; n <= 101; n++) begin
      go(n);
      total++;
      if (tx !== f[(n - 2) / 10]) begin
        bad++;
        $display("FAIL mrst_bit c%0d tx=%b want %b",
                 n, tx, f[(n - 2) / 10]);
      end
    end
    go(102);
    total++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL mrst_end busy/tx=%b%b want 01", busy, tx);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cur = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overwrite();
    test_parity();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the PicoBlaze I/O subsystem. Takes bytes from a processor output-port write strobe and serialises them as asynchronous 8N1 frames (optional parity) onto the TX line. The TX line passes to the top-level output buffer. A one-byte holding register double-buffers the processor write against the shift register, so back-to-back frames need no idle gap.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bits/s.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: parity sense when PARITY_EN=1; 1 = odd, 0 = even.

- SYS_CLK  in  1  system clock; the only clock; all logic on its rising edge.
- SYS_RST  in  1  reset; asynchronous, active-low.
- i_load  in  1  write strobe; one cycle per byte.
- i_data  in  8  byte to send; sampled when i_load=1.
- o_TX  out  1  serial line; idle high.
- o_TXRDY  out  1  high when the holding register is empty and can accept a write.
- o_BUSY  out  1  high while a frame is on the line (START through STOP).

## Operation
- BIT_TIME = CLK_FREQ / BAUD, with the integer quotient truncated. At defaults this is 868. BIT_TIME < 2 is a compile-time error.
- Bit order on the line:
  - start bit: 0
  - data bits, LSB first
  - parity bit (only if PARITY_EN=1): XOR of the data, inverted when PARITY_ODD=1
  - one stop bit: 1
- Write acceptance:
  - A write with i_load=1 and o_TXRDY=1 stores i_data in the holding register and makes the holding register full.
  - A write with o_TXRDY=0 is discarded with no side effect. This includes a write in the cycle of a holding-to-shift transfer.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the holding register is full. The transfer copies holding to shift, marks holding empty and drives o_TX=0.
  - START -> DATA after BIT_TIME cycles.
  - DATA shifts out 8 bits, each lasting BIT_TIME cycles, using a 3-bit index. It then moves to PARITY if PARITY_EN=1, else to STOP.
  - PARITY -> STOP after BIT_TIME cycles.
  - STOP lasts BIT_TIME cycles. In its last cycle:
    - if holding is full, transfer and go directly to START (no idle bit);
    - otherwise go to IDLE.
- Bit counter: counts 0..BIT_TIME-1, is cleared on every state change, and is held at 0 in IDLE.
- o_TX is registered; no combinational path from any input to o_TX.
- o_BUSY = (state != IDLE); it is registered.
- Reset values: o_TX=1, o_TXRDY=1, o_BUSY=0, state IDLE, holding empty, counters 0.
- Reset asserted mid-frame aborts the frame immediately and asynchronously: o_TX returns to 1 and the holding contents are lost.

## Timing
- Cycle numbering: cycle 0 is the cycle in which i_load=1 is sampled while IDLE with holding empty.
  - Cycle 1: holding full, o_TXRDY=0.
  - Cycle 2: o_TX=0 (start bit), o_TXRDY=1, o_BUSY=1.
- Load-to-start-bit latency is 2 cycles.
- Frame length is 10·BIT_TIME cycles, or 11·BIT_TIME with parity.
- o_BUSY falls in the cycle after the last stop-bit cycle if no byte is pending.
- Second byte written while the first byte is in flight:
  - its start bit begins exactly 10·BIT_TIME cycles after the first start bit;
  - o_TXRDY rises again in that same cycle.
- Throughput is one byte per frame time. The writer must poll o_TXRDY.

## Structure
- Shared package uart_pkg holds:
  - the FSM state encoding;
  - the BIT_TIME derivation function;
  - the frame-length constants (START=1, DATA=8, STOP=1).
- Sub-module baud_gen (parameter BIT_TIME) provides the per-bit cycle counter. Inputs: clear, enable. Output: a one-cycle bit_done pulse in count BIT_TIME-1.
- uart_tx contains the holding register, shift register, FSM and parity logic.

## Test plan
All scenarios use CLK_FREQ=1_000_000 and BAUD=100_000, so BIT_TIME=10.
- Reset: after release, o_TX=1, o_TXRDY=1, o_BUSY=0. The line stays high for 200 idle cycles.
- Single byte: write 0x55 with no parity.
  - o_TX=0 at cycle 2, then 1,0,1,0,1,0,1,0, then stop=1, each bit 10 cycles.
  - o_BUSY drops at cycle 102.
- Back-to-back: write 0xA3, then write 0x0F at cycle 5 once o_TXRDY is high. The second start bit begins at cycle 102 with no idle bit between frames.
- Overwrite: write 0x11, then write 0x22 at cycle 2 and 0x33 at cycle 3.
  - 0x22 is accepted into holding (o_TXRDY=1 at cycle 2).
  - 0x33 is discarded (o_TXRDY=0).
  - Only 0x11 then 0x22 appear on the line.
- Parity (PARITY_EN=1): write 0x07.
  - With PARITY_ODD=0: parity bit=1, frame is 110 cycles.
  - With PARITY_ODD=1: parity bit=0.
- Mid-frame reset: assert SYS_RST low during data bit 3 of 0xFF.
  - o_TX=1 asynchronously and o_BUSY=0.
  - After release, a new write of 0x81 transmits correctly.
